// File: rtl/cache_req_master_pkg.sv
// Shared widths, AXI channel bundles and the command record for the
// cache-side request master.
package cache_req_master_pkg;

   localparam int CHWIDTH       = 1;
   localparam int RKWIDTH       = 1;
   localparam int BGWIDTH       = 2;
   localparam int BKWIDTH       = 2;
   localparam int RWIDTH        = 8;
   localparam int CWIDTH        = 6;
   localparam int AXI_ADDRWIDTH = 32;
   localparam int AXI_IDWIDTH   = 4;
   localparam int AXI_USERWIDTH = 2;
   localparam int AXI_DATAWIDTH = 32;
   localparam int BURST_LENGTH  = 4;
   localparam int BEATW = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;

   typedef struct packed {
      logic [AXI_IDWIDTH-1:0]   id;
      logic [AXI_ADDRWIDTH-1:0] addr;
      logic [AXI_USERWIDTH-1:0] user;
   } axi_a_t;

   typedef struct packed {
      logic [AXI_IDWIDTH-1:0]     id;
      logic [AXI_DATAWIDTH-1:0]   data;
      logic [AXI_DATAWIDTH/8-1:0] strb;
      logic                       last;
      logic [AXI_USERWIDTH-1:0]   user;
   } axi_w_t;

   typedef struct packed {
      logic [AXI_IDWIDTH-1:0]   id;
      logic [AXI_DATAWIDTH-1:0] data;
      logic [1:0]               resp;
      logic                     last;
      logic [AXI_USERWIDTH-1:0] user;
   } axi_r_t;

   typedef struct packed {
      logic [AXI_IDWIDTH-1:0]   id;
      logic [1:0]               resp;
      logic [AXI_USERWIDTH-1:0] user;
   } axi_b_t;

   typedef struct packed {
      logic   ar_valid;
      axi_a_t ar;
      logic   aw_valid;
      axi_a_t aw;
      logic   w_valid;
      axi_w_t w;
      logic   r_ready;
      logic   b_ready;
   } cache_side_request;

   typedef struct packed {
      logic   ar_ready;
      logic   aw_ready;
      logic   w_ready;
      logic   r_valid;
      axi_r_t r;
      logic   b_valid;
      axi_b_t b;
   } cache_side_response;

   typedef struct packed {
      logic                     write;
      logic [CHWIDTH-1:0]       ch;
      logic [RKWIDTH-1:0]       rk;
      logic [BGWIDTH-1:0]       bg;
      logic [BKWIDTH-1:0]       bk;
      logic [RWIDTH-1:0]        row;
      logic [CWIDTH-1:0]        col;
      logic [AXI_IDWIDTH-1:0]   id;
      logic [AXI_USERWIDTH-1:0] user;
   } cmd_t;

   function automatic logic [AXI_ADDRWIDTH-1:0] pack_addr(input cmd_t c);
      return AXI_ADDRWIDTH'({c.ch, c.rk, c.bg, c.bk, c.row, c.col});
   endfunction

endpackage

// File: rtl/cache_req_master_if.sv
// Cache-side request/response bus between the request master and the
// memory controller.
interface cache_req_master_if;
   import cache_req_master_pkg::*;

   cache_side_request  cache_req;
   cache_side_response cache_resp;

   modport master (output cache_req, input cache_resp);
   modport slave  (input cache_req, output cache_resp);
endinterface

// File: rtl/cache_req_master_outstanding_tracker.sv
// In-flight counter for one direction: issue/complete accounting, full
// flag, underflow pulse and wrapping completion counter.
module cache_req_outstanding_tracker #(
   parameter int MAX_OUT  = 4,
   parameter int CNTWIDTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                issue,
   input  logic                done,
   output logic                full,
   output logic                pending,
   output logic                underflow,
   output logic [CNTWIDTH-1:0] done_cnt
);
   localparam int OW = $clog2(MAX_OUT + 1);

   logic [OW-1:0] cnt;

   assign full      = (cnt >= OW'(MAX_OUT));
   assign pending   = (cnt != '0);
   assign underflow = done && !pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         done_cnt <= '0;
      end else begin
         if (issue && !done)
            cnt <= cnt + OW'(1);
         else if (done && !issue && pending)
            cnt <= cnt - OW'(1);
         if (done)
            done_cnt <= done_cnt + CNTWIDTH'(1);
      end
   end
endmodule

// File: rtl/cache_req_master.sv
// Cycle-accurate cache-side AXI-style source: one command per idle visit,
// AR or AW+W burst, with completion and protocol-error tracking.
module cache_req_master
   import cache_req_master_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNTWIDTH        = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     cmd_write,
   input  logic [CHWIDTH-1:0]       cmd_ch,
   input  logic [RKWIDTH-1:0]       cmd_rk,
   input  logic [BGWIDTH-1:0]       cmd_bg,
   input  logic [BKWIDTH-1:0]       cmd_bk,
   input  logic [RWIDTH-1:0]        cmd_row,
   input  logic [CWIDTH-1:0]        cmd_col,
   input  logic [AXI_IDWIDTH-1:0]   cmd_id,
   input  logic [AXI_USERWIDTH-1:0] cmd_user,
   cache_req_master_if.master       bus,
   output logic                     busy,
   output logic [CNTWIDTH-1:0]      rd_done_cnt,
   output logic [CNTWIDTH-1:0]      wr_done_cnt,
   output logic                     err
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_AR   = 2'd1;
   localparam logic [1:0] S_AW   = 2'd2;
   localparam logic [1:0] S_W    = 2'd3;

   logic [1:0]     state;
   logic           live;
   cmd_t           q;
   cmd_t           cmd_in;
   logic [BEATW-1:0] wbeat;
   logic [BEATW:0]   rbeat;
   logic rd_full, wr_full, rd_pend, wr_pend, rd_uf, wr_uf;
   logic cmd_fire, ar_fire, aw_fire, w_fire, w_end;
   logic r_fire, r_end, b_fire, r_short;
   logic unused_resp;

   assign cmd_in = {cmd_write, cmd_ch, cmd_rk, cmd_bg, cmd_bk,
                    cmd_row, cmd_col, cmd_id, cmd_user};

   assign cmd_ready = live && (state == S_IDLE) &&
                      (cmd_write ? !wr_full : !rd_full);
   assign cmd_fire  = cmd_valid && cmd_ready;
   assign ar_fire   = (state == S_AR) && bus.cache_resp.ar_ready;
   // AW only completes together with w_ready, as the controller expects
   assign aw_fire   = (state == S_AW) && bus.cache_resp.aw_ready &&
                      bus.cache_resp.w_ready;
   assign w_fire    = (state == S_W) && bus.cache_resp.w_ready;
   assign w_end     = w_fire && (wbeat == BEATW'(BURST_LENGTH - 1));
   assign r_fire    = live && bus.cache_resp.r_valid;
   assign r_end     = r_fire && bus.cache_resp.r.last;
   assign r_short   = r_end && (rbeat != (BEATW+1)'(BURST_LENGTH - 1));
   assign b_fire    = live && bus.cache_resp.b_valid;
   assign busy      = (state != S_IDLE) || rd_pend || wr_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         live  <= 1'b0;
         q     <= '0;
         wbeat <= '0;
         rbeat <= '0;
         err   <= 1'b0;
      end else begin
         live <= 1'b1;
         unique case (state)
            S_IDLE: if (cmd_fire) begin
               q     <= cmd_in;
               state <= cmd_write ? S_AW : S_AR;
            end
            S_AR: if (ar_fire) state <= S_IDLE;
            S_AW: if (aw_fire) begin
               wbeat <= '0;
               state <= S_W;
            end
            S_W: if (w_fire) begin
               wbeat <= wbeat + BEATW'(1);
               if (w_end) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         if (r_end)
            rbeat <= '0;
         else if (r_fire && !(&rbeat))
            rbeat <= rbeat + (BEATW+1)'(1);
         if (r_short || rd_uf || wr_uf)
            err <= 1'b1;
      end
   end

   always_comb begin
      bus.cache_req          = '0;
      bus.cache_req.r_ready  = live;
      bus.cache_req.b_ready  = live;
      bus.cache_req.ar_valid = (state == S_AR);
      bus.cache_req.ar.id    = q.id;
      bus.cache_req.ar.addr  = pack_addr(q);
      bus.cache_req.ar.user  = q.user;
      bus.cache_req.aw_valid = (state == S_AW);
      bus.cache_req.aw.id    = q.id;
      bus.cache_req.aw.addr  = pack_addr(q);
      bus.cache_req.aw.user  = q.user;
      bus.cache_req.w_valid  = (state == S_W);
      bus.cache_req.w.id     = q.id;
      bus.cache_req.w.user   = q.user;
      bus.cache_req.w.data   = AXI_DATAWIDTH'({q.id, wbeat});
      bus.cache_req.w.strb   = '1;
      bus.cache_req.w.last   = (state == S_W) &&
                               (wbeat == BEATW'(BURST_LENGTH - 1));
   end

   assign unused_resp = ^{q.write, bus.cache_resp.r.id,
                          bus.cache_resp.r.data, bus.cache_resp.r.resp,
                          bus.cache_resp.r.user, bus.cache_resp.b};

   cache_req_outstanding_tracker #(
      .MAX_OUT (MAX_OUTSTANDING),
      .CNTWIDTH(CNTWIDTH)
   ) u_rd (
      .clk      (clk),
      .rst_n    (rst_n),
      .issue    (ar_fire),
      .done     (r_end),
      .full     (rd_full),
      .pending  (rd_pend),
      .underflow(rd_uf),
      .done_cnt (rd_done_cnt)
   );

   cache_req_outstanding_tracker #(
      .MAX_OUT (MAX_OUTSTANDING),
      .CNTWIDTH(CNTWIDTH)
   ) u_wr (
      .clk      (clk),
      .rst_n    (rst_n),
      .issue    (aw_fire),
      .done     (b_fire),
      .full     (wr_full),
      .pending  (wr_pend),
      .underflow(wr_uf),
      .done_cnt (wr_done_cnt)
   );
endmodule

// File: tb/tb_cache_req_master.sv
// Self-checking bench for cache_req_master: command table, scoreboarded
// AR/AW/W traffic and hand-built stall/overflow/reset sequences.
module tb_cache_req_master;
   import cache_req_master_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                     cmd_valid, cmd_ready, cmd_write;
   logic [CHWIDTH-1:0]       cmd_ch;
   logic [RKWIDTH-1:0]       cmd_rk;
   logic [BGWIDTH-1:0]       cmd_bg;
   logic [BKWIDTH-1:0]       cmd_bk;
   logic [RWIDTH-1:0]        cmd_row;
   logic [CWIDTH-1:0]        cmd_col;
   logic [AXI_IDWIDTH-1:0]   cmd_id;
   logic [AXI_USERWIDTH-1:0] cmd_user;
   logic                     busy, err;
   logic [15:0]              rd_done_cnt, wr_done_cnt;

   cache_req_master_if bus();

   cache_req_master dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_write  (cmd_write),
      .cmd_ch     (cmd_ch),
      .cmd_rk     (cmd_rk),
      .cmd_bg     (cmd_bg),
      .cmd_bk     (cmd_bk),
      .cmd_row    (cmd_row),
      .cmd_col    (cmd_col),
      .cmd_id     (cmd_id),
      .cmd_user   (cmd_user),
      .bus        (bus),
      .busy       (busy),
      .rd_done_cnt(rd_done_cnt),
      .wr_done_cnt(wr_done_cnt),
      .err        (err)
   );

   typedef struct {
      logic [AXI_ADDRWIDTH-1:0] addr;
      logic [AXI_IDWIDTH-1:0]   id;
   } a_exp_t;

   typedef struct {
      logic [AXI_DATAWIDTH-1:0] data;
      logic                     last;
   } w_exp_t;

   typedef struct {
      logic                     wr;
      logic [CHWIDTH-1:0]       ch;
      logic [RKWIDTH-1:0]       rk;
      logic [BGWIDTH-1:0]       bg;
      logic [BKWIDTH-1:0]       bk;
      logic [RWIDTH-1:0]        row;
      logic [CWIDTH-1:0]        col;
      logic [AXI_IDWIDTH-1:0]   id;
      logic [AXI_ADDRWIDTH-1:0] addr;
   } vec_t;

   a_exp_t ar_q[$];
   a_exp_t aw_q[$];
   w_exp_t w_q[$];
   a_exp_t ea;
   w_exp_t ew;
   vec_t   vecs[4];

   int checks = 0;
   int failures = 0;
   int exp_rd = 0;
   int exp_wr = 0;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Handshakes sampled mid-cycle; they complete on the following posedge.
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (bus.cache_req.ar_valid && bus.cache_resp.ar_ready) begin
            chk("ar_expected", 64'(ar_q.size() != 0), 64'(1));
            if (ar_q.size() != 0) begin
               ea = ar_q.pop_front();
               chk("ar_addr", 64'(bus.cache_req.ar.addr), 64'(ea.addr));
               chk("ar_id", 64'(bus.cache_req.ar.id), 64'(ea.id));
            end
         end
         if (bus.cache_req.aw_valid && bus.cache_resp.aw_ready &&
             bus.cache_resp.w_ready) begin
            chk("aw_expected", 64'(aw_q.size() != 0), 64'(1));
            if (aw_q.size() != 0) begin
               ea = aw_q.pop_front();
               chk("aw_addr", 64'(bus.cache_req.aw.addr), 64'(ea.addr));
               chk("aw_id", 64'(bus.cache_req.aw.id), 64'(ea.id));
            end
         end
         if (bus.cache_req.w_valid && bus.cache_resp.w_ready) begin
            chk("w_expected", 64'(w_q.size() != 0), 64'(1));
            if (w_q.size() != 0) begin
               ew = w_q.pop_front();
               chk("w_data", 64'(bus.cache_req.w.data), 64'(ew.data));
               chk("w_last", 64'(bus.cache_req.w.last), 64'(ew.last));
               chk("w_strb", 64'(bus.cache_req.w.strb), 64'(4'hF));
            end
         end
      end
   end

   task automatic send_cmd(input logic wr, input logic [CHWIDTH-1:0] ch,
                           input logic [RKWIDTH-1:0] rk,
                           input logic [BGWIDTH-1:0] bg,
                           input logic [BKWIDTH-1:0] bk,
                           input logic [RWIDTH-1:0] row,
                           input logic [CWIDTH-1:0] col,
                           input logic [AXI_IDWIDTH-1:0] id,
                           input logic [AXI_ADDRWIDTH-1:0] eaddr);
      int n;
      logic [AXI_DATAWIDTH-1:0] d;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_ch = ch;
      cmd_rk = rk;
      cmd_bg = bg;
      cmd_bk = bk;
      cmd_row = row;
      cmd_col = col;
      cmd_id = id;
      #1;
      n = 0;
      while (!cmd_ready && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("cmd_accept", 64'(cmd_ready), 64'(1));
      if (cmd_ready) begin
         if (wr) begin
            aw_q.push_back('{eaddr, id});
            for (int b = 0; b < BURST_LENGTH; b++) begin
               d = AXI_DATAWIDTH'(id);
               d = (d << BEATW) | AXI_DATAWIDTH'(b);
               w_q.push_back('{d, (b == BURST_LENGTH - 1)});
            end
         end else begin
            ar_q.push_back('{eaddr, id});
         end
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((ar_q.size() + aw_q.size() + w_q.size()) != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(ar_q.size() + aw_q.size() + w_q.size()), 64'(0));
   endtask

   task automatic r_burst(input int n);
      for (int i = 0; i < n; i++) begin
         bus.cache_resp.r_valid = 1'b1;
         bus.cache_resp.r.last = (i == n - 1);
         @(negedge clk);
      end
      bus.cache_resp.r_valid = 1'b0;
      bus.cache_resp.r.last = 1'b0;
   endtask

   task automatic b_resp();
      bus.cache_resp.b_valid = 1'b1;
      @(negedge clk);
      bus.cache_resp.b_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 8'h00, 6'h00, 4'd3,
                  32'h0008_0000};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 2'd3, 2'd2, 8'hFF, 6'h3F, 4'd5,
                  32'h0003_BFFF};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 2'd2, 2'd3, 8'h12, 6'h05, 4'd9,
                  32'h000E_C485};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'h00, 6'h2A, 4'd15,
                  32'h0000_002A};

      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_ch = '0;
      cmd_rk = '0;
      cmd_bg = '0;
      cmd_bk = '0;
      cmd_row = '0;
      cmd_col = '0;
      cmd_id = '0;
      cmd_user = '0;
      bus.cache_resp = '0;

      // reset and idle
      repeat (2) @(negedge clk);
      #1;
      chk("rst_r_ready", 64'(bus.cache_req.r_ready), 64'(0));
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rst_w_last", 64'(bus.cache_req.w.last), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_r_ready", 64'(bus.cache_req.r_ready), 64'(1));
      chk("idle_b_ready", 64'(bus.cache_req.b_ready), 64'(1));
      chk("idle_valids", 64'({bus.cache_req.ar_valid,
          bus.cache_req.aw_valid, bus.cache_req.w_valid}), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_cnts", 64'({rd_done_cnt, wr_done_cnt}), 64'(0));
      chk("idle_err", 64'(err), 64'(0));
      chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));

      // read with ar_ready stalled for 3 cycles
      @(negedge clk);
      bus.cache_resp.ar_ready = 1'b0;
      bus.cache_resp.aw_ready = 1'b1;
      bus.cache_resp.w_ready = 1'b1;
      send_cmd(1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 8'd0, 6'd4, 4'd2,
               32'h0005_4004);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ar_hold_valid", 64'(bus.cache_req.ar_valid), 64'(1));
         chk("ar_hold_addr", 64'(bus.cache_req.ar.addr), 64'(32'h54004));
         @(negedge clk);
      end
      bus.cache_resp.ar_ready = 1'b1;
      #1;
      chk("ar_4th_valid", 64'(bus.cache_req.ar_valid), 64'(1));
      @(negedge clk);
      #1;
      chk("ar_drop", 64'(bus.cache_req.ar_valid), 64'(0));
      chk("ar_busy", 64'(busy), 64'(1));
      @(negedge clk);
      r_burst(BURST_LENGTH);
      exp_rd++;
      #1;
      chk("rd_done_1", 64'(rd_done_cnt), 64'(exp_rd));
      chk("rd_busy_0", 64'(busy), 64'(0));

      // write with w_ready low for 5 cycles and a mid-burst stall
      @(negedge clk);
      bus.cache_resp.w_ready = 1'b0;
      send_cmd(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd1, 6'd0, 4'd1,
               32'h0000_0040);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("aw_wait_valid", 64'(bus.cache_req.aw_valid), 64'(1));
         chk("aw_wait_no_w", 64'(bus.cache_req.w_valid), 64'(0));
         @(negedge clk);
      end
      bus.cache_resp.w_ready = 1'b1;
      @(negedge clk);
      bus.cache_resp.w_ready = 1'b0;
      #1;
      chk("w0_valid", 64'(bus.cache_req.w_valid), 64'(1));
      chk("w0_data", 64'(bus.cache_req.w.data), 64'(4));
      chk("w0_last", 64'(bus.cache_req.w.last), 64'(0));
      @(negedge clk);
      #1;
      chk("w0_hold", 64'(bus.cache_req.w.data), 64'(4));
      @(negedge clk);
      bus.cache_resp.w_ready = 1'b1;
      repeat (2) @(negedge clk);
      bus.cache_resp.w_ready = 1'b0;
      #1;
      chk("w2_hold_data", 64'(bus.cache_req.w.data), 64'(6));
      chk("w2_hold_last", 64'(bus.cache_req.w.last), 64'(0));
      @(negedge clk);
      bus.cache_resp.w_ready = 1'b1;
      wait_drain("wr_drain");
      b_resp();
      exp_wr++;
      #1;
      chk("wr_done_1", 64'(wr_done_cnt), 64'(exp_wr));
      chk("wr_busy_0", 64'(busy), 64'(0));

      // command table with an always-ready slave
      for (int v = 0; v < 4; v++) begin
         @(negedge clk);
         send_cmd(vecs[v].wr, vecs[v].ch, vecs[v].rk, vecs[v].bg,
                  vecs[v].bk, vecs[v].row, vecs[v].col, vecs[v].id,
                  vecs[v].addr);
         wait_drain("vec_drain");
         if (vecs[v].wr) begin
            b_resp();
            exp_wr++;
         end else begin
            r_burst(BURST_LENGTH);
            exp_rd++;
         end
         #1;
         chk("vec_rd_done", 64'(rd_done_cnt), 64'(exp_rd));
         chk("vec_wr_done", 64'(wr_done_cnt), 64'(exp_wr));
         chk("vec_busy", 64'(busy), 64'(0));
      end
      chk("vec_err", 64'(err), 64'(0));

      // read limit: fifth read blocked until one completes
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         send_cmd(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, CWIDTH'(k),
                  AXI_IDWIDTH'(k), AXI_ADDRWIDTH'(k));
         wait_drain("lim_drain");
      end
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      #1;
      chk("rd_full_block", 64'(cmd_ready), 64'(0));
      cmd_write = 1'b1;
      #1;
      chk("wr_not_full", 64'(cmd_ready), 64'(1));
      cmd_write = 1'b0;
      cmd_valid = 1'b0;
      @(negedge clk);
      r_burst(BURST_LENGTH);
      exp_rd++;
      #1;
      chk("rd_reopen", 64'(cmd_ready), 64'(1));
      @(negedge clk);
      send_cmd(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 6'd4, 4'd4,
               32'h0000_0004);
      wait_drain("lim5_drain");
      for (int k = 0; k < 4; k++) r_burst(BURST_LENGTH);
      exp_rd += 4;
      #1;
      chk("lim_rd_done", 64'(rd_done_cnt), 64'(exp_rd));
      chk("lim_busy", 64'(busy), 64'(0));
      chk("lim_err", 64'(err), 64'(0));

      // B response in the same cycle as an AW handshake
      @(negedge clk);
      send_cmd(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 6'd6, 4'd6,
               32'h0000_0006);
      wait_drain("same_a_drain");
      bus.cache_resp.aw_ready = 1'b0;
      send_cmd(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 6'd7, 4'd7,
               32'h0000_0007);
      bus.cache_resp.aw_ready = 1'b1;
      bus.cache_resp.b_valid = 1'b1;
      @(negedge clk);
      bus.cache_resp.b_valid = 1'b0;
      exp_wr++;
      #1;
      chk("same_wr_done", 64'(wr_done_cnt), 64'(exp_wr));
      @(negedge clk);
      wait_drain("same_b_drain");
      b_resp();
      exp_wr++;
      #1;
      chk("same_wr_done2", 64'(wr_done_cnt), 64'(exp_wr));
      chk("same_busy", 64'(busy), 64'(0));
      chk("same_err", 64'(err), 64'(0));

      // B underflow, then reset in the middle of a W burst
      @(negedge clk);
      b_resp();
      exp_wr++;
      #1;
      chk("uf_err", 64'(err), 64'(1));
      chk("uf_wr_done", 64'(wr_done_cnt), 64'(exp_wr));
      chk("uf_busy", 64'(busy), 64'(0));
      @(negedge clk);
      send_cmd(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 6'd3, 4'd3,
               32'h0000_0003);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_w_valid", 64'(bus.cache_req.w_valid), 64'(0));
      chk("mid_rst_err", 64'(err), 64'(0));
      chk("mid_rst_cnts", 64'({rd_done_cnt, wr_done_cnt}), 64'(0));
      chk("mid_rst_r_ready", 64'(bus.cache_req.r_ready), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      ar_q.delete();
      aw_q.delete();
      w_q.delete();
      exp_rd = 0;
      exp_wr = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_r_ready", 64'(bus.cache_req.r_ready), 64'(1));
      chk("post_rst_w_valid", 64'(bus.cache_req.w_valid), 64'(0));

      // R last arriving after too few beats
      @(negedge clk);
      send_cmd(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 6'd4, 4'd4,
               32'h0000_0004);
      wait_drain("short_drain");
      r_burst(2);
      exp_rd++;
      #1;
      chk("short_err", 64'(err), 64'(1));
      chk("short_rd_done", 64'(rd_done_cnt), 64'(exp_rd));
      chk("short_busy", 64'(busy), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cache_req_master.md
Name: cache_req_master

Overview:
- Synthesizable cache-side request master that sits directly upstream of the MemoryController's cache_req/cache_resp port.
- Replaces task-driven stimulus with a cycle-accurate AXI-style source.
- Accepts one command per handshake (read or write, decomposed address), then drives AR, or AW followed by a full W burst.
- Holds r_ready/b_ready high, tracks outstanding transactions, and counts completions and protocol errors.

Parameters:
- CHWIDTH, from package: channel field width
- RKWIDTH, BGWIDTH, BKWIDTH, RWIDTH, CWIDTH, from package: rank / bankgroup / bank / row / column field widths
- AXI_IDWIDTH, AXI_USERWIDTH, AXI_DATAWIDTH, from package: AXI ID, user and data widths
- BURST_LENGTH, from package: W beats per write and R beats per read
- MAX_OUTSTANDING, 4: read and write in-flight limit, applied separately to each
- CNTWIDTH, 16: width of the completion counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_ch / cmd_rk / cmd_bg / cmd_bk / cmd_row / cmd_col  in  field widths  address fields
- cmd_id  in  AXI_IDWIDTH  transaction ID
- cmd_user  in  AXI_USERWIDTH  user field
- cache_req  out  cache_side_request  AR/AW/W channels plus r_ready/b_ready
- cache_resp  in  cache_side_response  ar_ready, aw_ready, w_ready, R and B channels
- busy  out  1  FSM not IDLE, or any transaction outstanding
- rd_done_cnt  out  CNTWIDTH  completed reads (R last beats)
- wr_done_cnt  out  CNTWIDTH  completed writes (B responses)
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n=0, async):
  - all valids 0, w.last 0, r_ready=b_ready=0
  - counters 0, err 0, FSM IDLE, cmd_ready 0
- First clk after reset release: r_ready=b_ready=1; both stay 1 until the next reset.
- Address packing: addr = {ch, rk, bg, bk, row, col}, MSB first, zero-extended to AXI_ADDRWIDTH.
- FSM states: IDLE, AR, AW, W.
- IDLE:
  - cmd_ready=1 iff the outstanding counter for the command type is < MAX_OUTSTANDING.
  - On cmd_valid&&cmd_ready: latch the command; go to AR (read) or AW (write).
- AR:
  - ar_valid=1, ar fields held stable.
  - Handshake when ar_ready=1: rd_outstanding++, next cycle ar_valid=0, go to IDLE.
- AW:
  - aw_valid=1.
  - Handshake only when aw_ready && w_ready are both 1 (controller convention).
  - On handshake: wr_outstanding++, beat counter=0, go to W.
- W:
  - w_valid=1, w.id/w.user from the latched command.
  - w.data = {cmd_id, beat index} zero-extended; w.strb = all ones.
  - w.last = 1 on beat BURST_LENGTH-1.
  - A beat advances only when w_ready=1; data and last are held while w_ready=0.
  - After the last beat is accepted: w_valid=0, go to IDLE.
- cmd_ready is 0 in every state except IDLE, so at most one command is issued per idle visit; back-to-back issue costs 1 IDLE cycle.
- R channel:
  - On r_valid: per-ID-agnostic beat counter increments.
  - On r.last: rd_outstanding--, rd_done_cnt++, beat counter cleared.
  - r.last with beat count != BURST_LENGTH-1 sets err.
- B channel: on b_valid, wr_outstanding--, wr_done_cnt++.
- Simultaneous events:
  - Issue and completion of the same type in one cycle leave the outstanding count unchanged.
  - Both done counters may increment in the same cycle.
- Underflow: a response while the matching outstanding count == 0 sets err; the count stays 0 and the done counter still increments.
- Done counters wrap modulo 2^CNTWIDTH.
- err clears only on reset.
- Reset mid-burst: everything returns to reset values immediately; no partial-burst completion.

Decomposition:
- cache_side_request/response structs, address widths, BURST_LENGTH and AXI widths stay in MemoryController_Definitions.
- Add a packed cmd struct (write, address fields, id, user) to the same package.
- Natural sub-module: cache_req_outstanding_tracker.
  - One instance per direction.
  - Contains the up/down counter, full flag, underflow error and done counter.

Test Plan:
1. Reset then idle: after release, r_ready=b_ready=1, all valids 0, busy 0, counters 0.
2. Read cmd (ch0, rk1, bg1, bk1, row0, col4, id2) with ar_ready stalled 3 cycles:
   - ar_valid is held for 4 cycles with addr constant, then drops.
   - Return BURST_LENGTH R beats with last → rd_done_cnt=1, busy=0.
3. Write (id1) with aw_ready=1 but w_ready=0 for 5 cycles:
   - No AW handshake until w_ready rises.
   - W beats carry data {1, 0..BURST_LENGTH-1}, last only on the final beat.
   - Toggling w_ready mid-burst holds the beat.
   - B → wr_done_cnt=1.
4. Issue 5 reads with no responses (MAX_OUTSTANDING=4): cmd_ready=0 for the 5th; first R last re-enables it.
5. Inject b_valid with no write outstanding → err=1, wr_done_cnt=1; assert rst_n mid-W burst → w_valid=0 asynchronously, err=0.
6. Same-cycle B response and AW handshake → wr_outstanding unchanged, wr_done_cnt +1.
